fpu_rr_scheduler: RTL and testbench

- Shares one FPU adder instance among N_REQ requesters using round-robin arbitration.
- Per transaction: accepts one operand pair, issues it to the FPU with a one-cycle start pulse, and waits for the FPU done pulse or a timeout. It then returns the result and status to the owning requester.
- Sits between the requester datapaths and the FPU. It is the only block that drives FPU operands.

---
 rtl/fpu_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_fpu_rr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler that shares one FPU adder among N_REQ requesters.
// Each transaction: grant in IDLE, pulse start in ISSUE, wait for done/timeout, hold result in RESPOND.
module fpu_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic                  clock_100Khz,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_op_a,
  input  logic [32*N_REQ-1:0]   req_op_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [3:0]            rsp_status,
  output logic                  rsp_timeout,
  output logic [31:0]           fpu_op_a,
  output logic [31:0]           fpu_op_b,
  output logic                  fpu_start,
  input  logic                  fpu_done,
  input  logic [31:0]           fpu_data,
  input  logic [3:0]            fpu_status,
  output logic                  busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [3:0] ST_EXACT   = 4'd2;
  localparam logic [3:0] ST_INEXACT = 4'd3;

  logic [1:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    wait_cnt;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [N_REQ-1:0] grant_oh;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (int'(p) == N_REQ - 1) return '0;
    else return p + 1'b1;
  endfunction

  // Scan from rr_ptr upward with wraparound; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign grant_oh  = N_REQ'(1) << win_idx;
  assign req_ready = (state == S_IDLE && win_found && !reset) ? grant_oh : '0;
  assign fpu_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      wait_cnt    <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_status  <= ST_EXACT;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner    <= win_idx;
            fpu_op_a <= req_op_a[32*win_idx +: 32];
            fpu_op_b <= req_op_b[32*win_idx +: 32];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A done pulse coinciding with the last timeout cycle still delivers real data.
          if (fpu_done) begin
            rsp_data    <= fpu_data;
            rsp_status  <= fpu_status;
            rsp_timeout <= 1'b0;
            rsp_valid   <= N_REQ'(1) << owner;
            state       <= S_RESPOND;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_status  <= ST_INEXACT;
            rsp_timeout <= 1'b1;
            rsp_valid   <= N_REQ'(1) << owner;
            state       <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            rr_ptr    <= wrap_inc(owner);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler with a small behavioural FPU that answers a fixed delay after start.
module tb_fpu_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = 7;

  logic                clock_100Khz = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [31:0]         rsp_data;
  logic [3:0]          rsp_status;
  logic                rsp_timeout;
  logic [31:0]         fpu_op_a;
  logic [31:0]         fpu_op_b;
  logic                fpu_start;
  logic                fpu_done;
  logic [31:0]         fpu_data;
  logic [3:0]          fpu_status;
  logic                busy;

  int n_vec;
  int n_miss;

  logic        model_en;
  int          model_delay;
  logic [31:0] model_data;
  logic [3:0]  model_status;
  logic        mpend;
  int          mcnt;

  fpu_rr_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op_a     (req_op_a),
    .req_op_b     (req_op_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .rsp_timeout  (rsp_timeout),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_start    (fpu_start),
    .fpu_done     (fpu_done),
    .fpu_data     (fpu_data),
    .fpu_status   (fpu_status),
    .busy         (busy)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  // FPU model: done is raised model_delay cycles after the start cycle, for one cycle.
  initial begin
    fpu_done   = 1'b0;
    fpu_data   = '0;
    fpu_status = '0;
    mpend      = 1'b0;
    mcnt       = 0;
    forever begin
      @(negedge clock_100Khz);
      fpu_done = 1'b0;
      if (mpend) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          fpu_done   = 1'b1;
          fpu_data   = model_data;
          fpu_status = model_status;
          mpend      = 1'b0;
        end
      end
      if (fpu_start && model_en) begin
        mpend = 1'b1;
        mcnt  = model_delay;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock_100Khz);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 300) begin
      step();
      n++;
    end
    check_vec("rsp_wait_bound", 32'(rsp_valid != '0), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check_vec("idle_wait_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int grants;
    logic seen;
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b1;
    req_valid    = 4'hf;
    rsp_ready    = '0;
    model_en     = 1'b1;
    model_delay  = 2;
    model_data   = 32'h1234_5678;
    model_status = 4'd2;
    for (int i = 0; i < N_REQ; i++) begin
      req_op_a[32*i +: 32] = 32'hA000_0000 + i;
      req_op_b[32*i +: 32] = 32'hB000_0000 + i;
    end

    // Reset held three cycles with every requester valid.
    repeat (3) begin
      step();
      check_vec("rst_req_ready", 32'(req_ready), 32'd0);
    end
    check_vec("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_vec("rst_rsp_status", 32'(rsp_status), 32'd2);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_fpu_start", 32'(fpu_start), 32'd0);
    check_vec("rst_rsp_data", rsp_data, 32'd0);
    check_vec("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_vec("rst_fpu_op_a", fpu_op_a, 32'd0);
    check_vec("rst_fpu_op_b", fpu_op_b, 32'd0);
    reset     = 1'b0;
    req_valid = '0;
    step();

    // Round robin: all requesters valid, responses consumed at once.
    rsp_ready = 4'hf;
    req_valid = 4'hf;
    grants    = 0;
    n         = 0;
    while (grants < 6 && n < 400) begin
      #1;
      if (req_ready != '0) begin
        check_vec("rr_onehot", 32'($countones(req_ready)), 32'd1);
        check_vec("rr_grant", 32'(req_ready), 32'(1) << (grants % N_REQ));
        grants++;
      end
      step();
      n++;
    end
    req_valid = '0;
    check_vec("rr_grant_count", 32'(grants), 32'd6);
    wait_idle();

    // Priority rotation: last served was 1, so 0 wins, then 1.
    req_valid = 4'b0011;
    #1;
    check_vec("prio_wrap", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    wait_idle();
    req_valid = 4'b0011;
    #1;
    check_vec("prio_next", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    wait_idle();

    // Single request from requester 2, FPU answers 6 cycles after start.
    rsp_ready    = '0;
    model_delay  = 6;
    model_data   = 32'h4054_0000;
    model_status = 4'd2;
    req_op_a[95:64] = 32'h4010_0000;
    req_op_b[95:64] = 32'h4008_0000;
    req_valid = 4'b0100;
    #1;
    check_vec("sr_ready", 32'(req_ready), 32'd4);
    step();
    req_valid = '0;
    check_vec("sr_ready_drop", 32'(req_ready), 32'd0);
    check_vec("sr_start", 32'(fpu_start), 32'd1);
    check_vec("sr_op_a", fpu_op_a, 32'h4010_0000);
    check_vec("sr_op_b", fpu_op_b, 32'h4008_0000);
    step();
    check_vec("sr_start_pulse", 32'(fpu_start), 32'd0);
    wait_rsp(n);
    check_vec("sr_latency", 32'(n), 32'd6);
    check_vec("sr_rsp_valid", 32'(rsp_valid), 32'd4);
    check_vec("sr_rsp_data", rsp_data, 32'h4054_0000);
    check_vec("sr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_vec("sr_rsp_status", 32'(rsp_status), 32'd2);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    check_vec("sr_released", 32'(rsp_valid), 32'd0);
    check_vec("sr_idle", 32'(busy), 32'd0);

    // Timeout with a silent FPU, then backpressure.
    model_en  = 1'b0;
    req_valid = 4'b1000;
    #1;
    check_vec("to_ready", 32'(req_ready), 32'd8);
    step();
    req_valid = '0;
    check_vec("to_start", 32'(fpu_start), 32'd1);
    step();
    wait_rsp(n);
    check_vec("to_latency", 32'(n), 32'(TIMEOUT));
    check_vec("to_rsp_valid", 32'(rsp_valid), 32'd8);
    check_vec("to_rsp_data", rsp_data, 32'd0);
    check_vec("to_rsp_status", 32'(rsp_status), 32'd3);
    check_vec("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    repeat (5) begin
      step();
      check_vec("bp_hold", 32'({busy, rsp_valid}), 32'h18);
    end
    rsp_ready = 4'b0111;
    step();
    check_vec("bp_other_ready", 32'(rsp_valid), 32'd8);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;
    check_vec("bp_release", 32'(rsp_valid), 32'd0);
    model_en = 1'b1;

    // Reset in WAIT; the late done must be ignored and the pointer restarts at 0.
    model_delay = 10;
    req_valid   = 4'b0010;
    #1;
    check_vec("mw_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("mw_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      step();
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    check_vec("mw_quiet", 32'(seen), 32'd0);
    req_valid = 4'hf;
    #1;
    check_vec("mw_next_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    rsp_ready = 4'hf;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
